// File: rtl/eth_mdio_phy_ctrl.sv
// PHY bring-up and MDIO (clause 22) management: reset pulse, BMCR write, link poll,
// then host read/write commands arbitrated onto the same MDIO bus.
module eth_mdio_phy_ctrl #(
    parameter int          CLK_DIV   = 25,
    parameter logic [4:0]  PHY_ADDR  = 5'd16,
    parameter logic [15:0] BMCR_INIT = 16'h1140,
    parameter int          RST_HOLD  = 500000,
    parameter int          RST_WAIT  = 500000,
    parameter int          POLL_MAX  = 2000,
    parameter int          POLL_GAP  = 50000
) (
    input  logic        clk_hifreq,
    input  logic        rst,
    output logic        phy_rst_n,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        link_up,
    output logic        init_done,
    output logic        init_err
);

    typedef enum logic [2:0] {
        S_RST_HOLD, S_RST_WAIT, S_CFG_WR, S_POLL_RD, S_POLL_GAP, S_IDLE, S_HOST
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] poll_q, poll_d;
    logic        phy_rst_n_q, phy_rst_n_d;
    logic        link_up_q, link_up_d;
    logic        init_done_q, init_done_d;
    logic        init_err_q, init_err_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    // Frame engine state
    logic        act_q, mdc_q, mdo_q, oe_q, wr_q, ta_q;
    logic [31:0] div_q;
    logic [5:0]  bit_q;
    logic [63:0] frame_q;
    logic [15:0] rd_sh_q;

    logic        start, start_wr, tick, frame_done;
    logic [4:0]  start_reg;
    logic [15:0] start_data;
    logic [63:0] word;

    assign tick       = act_q && (div_q == 32'(CLK_DIV - 1));
    assign frame_done = tick && mdc_q && (bit_q == 6'd63);
    // Read frames keep mdio_o high while released so the bus idles at the pull-up level.
    assign word = {32'hFFFF_FFFF, 2'b01, (start_wr ? 2'b01 : 2'b10), PHY_ADDR, start_reg,
                   (start_wr ? 2'b10 : 2'b11), (start_wr ? start_data : 16'hFFFF)};

    always_ff @(posedge clk_hifreq or posedge rst) begin
        if (rst) begin
            state_q     <= S_RST_HOLD;
            cnt_q       <= '0;
            poll_q      <= '0;
            phy_rst_n_q <= 1'b0;
            link_up_q   <= 1'b0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            poll_q      <= poll_d;
            phy_rst_n_q <= phy_rst_n_d;
            link_up_q   <= link_up_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Host handshake: a command is taken on a clock edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in S_IDLE, so anything offered earlier simply waits.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        poll_d      = poll_q;
        phy_rst_n_d = phy_rst_n_q;
        link_up_d   = link_up_q;
        init_done_d = init_done_q;
        init_err_d  = init_err_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        start       = 1'b0;
        start_wr    = 1'b0;
        start_reg   = 5'd0;
        start_data  = 16'hFFFF;
        case (state_q)
            S_RST_HOLD: begin
                if (cnt_q == 32'(RST_HOLD - 1)) begin
                    phy_rst_n_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_RST_WAIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RST_WAIT: begin
                if (cnt_q == 32'(RST_WAIT - 1)) begin
                    cnt_d      = '0;
                    state_d    = S_CFG_WR;
                    start      = 1'b1;
                    start_wr   = 1'b1;
                    start_data = BMCR_INIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_CFG_WR: begin
                if (frame_done) begin
                    state_d   = S_POLL_RD;
                    start     = 1'b1;
                    start_reg = 5'd1;
                end
            end
            S_POLL_RD: begin
                if (frame_done) begin
                    if (!ta_q && rd_sh_q[2]) begin
                        link_up_d   = 1'b1;
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else if (poll_q + 32'd1 == 32'(POLL_MAX)) begin
                        poll_d      = poll_q + 32'd1;
                        init_err_d  = 1'b1;
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        poll_d  = poll_q + 32'd1;
                        cnt_d   = '0;
                        state_d = S_POLL_GAP;
                    end
                end
            end
            S_POLL_GAP: begin
                if (cnt_q == 32'(POLL_GAP - 1)) begin
                    cnt_d     = '0;
                    state_d   = S_POLL_RD;
                    start     = 1'b1;
                    start_reg = 5'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d    = S_HOST;
                    start      = 1'b1;
                    start_wr   = cmd_write;
                    start_reg  = cmd_reg;
                    start_data = cmd_wdata;
                end
            end
            S_HOST: begin
                if (frame_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = wr_q ? 1'b0 : ta_q;
                    if (!wr_q) rsp_rdata_d = rd_sh_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_RST_HOLD;
        endcase
    end

    // MDIO frame engine: drive on MDC falling edges, sample on MDC rising edges.
    always_ff @(posedge clk_hifreq or posedge rst) begin
        if (rst) begin
            act_q   <= 1'b0;
            mdc_q   <= 1'b0;
            mdo_q   <= 1'b1;
            oe_q    <= 1'b0;
            wr_q    <= 1'b0;
            ta_q    <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            rd_sh_q <= '0;
        end else if (start) begin
            act_q   <= 1'b1;
            mdc_q   <= 1'b0;
            mdo_q   <= word[63];
            oe_q    <= 1'b1;
            wr_q    <= start_wr;
            ta_q    <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            frame_q <= {word[62:0], 1'b1};
            rd_sh_q <= '0;
        end else if (act_q) begin
            if (tick) begin
                div_q <= '0;
                mdc_q <= ~mdc_q;
                if (!mdc_q) begin
                    if (!wr_q && bit_q == 6'd47) ta_q <= mdio_i;
                    if (!wr_q && bit_q >= 6'd48) rd_sh_q <= {rd_sh_q[14:0], mdio_i};
                end else if (bit_q == 6'd63) begin
                    act_q <= 1'b0;
                    oe_q  <= 1'b0;
                    mdo_q <= 1'b1;
                end else begin
                    bit_q   <= bit_q + 6'd1;
                    mdo_q   <= frame_q[63];
                    frame_q <= {frame_q[62:0], 1'b1};
                    oe_q    <= wr_q || (bit_q < 6'd45);
                end
            end else begin
                div_q <= div_q + 32'd1;
            end
        end
    end

    assign phy_rst_n = phy_rst_n_q;
    assign mdc       = mdc_q;
    assign mdio_o    = mdo_q;
    assign mdio_oe   = oe_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign link_up   = link_up_q;
    assign init_done = init_done_q;
    assign init_err  = init_err_q;

endmodule
